// File: rtl/noise_pack.sv
// Packs a serial noise bit stream (MSB first) into 32-bit words and queues them in a
// first-word-fall-through FIFO. Define NOISE_PACK_STATS_EN to enable word statistics.
module noise_pack #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_enable,
    input  logic        I_clear,
    input  logic        I_bit,
    input  logic        I_bit_valid,
    output logic        O_next,
    output logic [31:0] O_word,
    output logic        O_word_valid,
    input  logic        I_word_ready,
    output logic [4:0]  O_fifo_count,
    output logic [4:0]  O_bit_count,
    output logic        O_overflow,
    output logic [31:0] O_words_total,
    output logic [31:0] O_words_dropped,
    output logic [1:0]  O_dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        NEXT    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        shift_q, shift_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [4:0]         count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic               overflow_q;
    logic [31:0]        mem [FIFO_DEPTH];

    logic push_req, push_ok, pop, full, drop;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        push_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_enable) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!I_enable) begin
                    // Leaving capture throws away the partial word.
                    state_d   = IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end else if (I_bit_valid) begin
                    shift_d = {shift_q[30:0], I_bit};
                    if (bit_cnt_q == 5'd31) begin
                        push_req  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = NEXT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            NEXT: begin
                state_d = I_enable ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a word when the head leaves on the same edge.
    always_comb begin
        full    = (count_q == DEPTH_C);
        pop     = (count_q != 5'd0) && I_word_ready;
        push_ok = push_req && (!full || pop);
        drop    = push_req && full && !pop;
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + 5'd1;
        else if (!push_ok && pop) count_d = count_q - 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (I_clear) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            count_q   <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (drop)    overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !I_clear) mem[wr_ptr_q] <= shift_d;
    end

`ifdef NOISE_PACK_STATS_EN
    logic [31:0] total_q, dropped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q   <= '0;
            dropped_q <= '0;
        end else if (I_clear) begin
            total_q   <= '0;
            dropped_q <= '0;
        end else begin
            if (push_req && total_q != 32'hFFFF_FFFF) total_q   <= total_q + 32'd1;
            if (drop && dropped_q != 32'hFFFF_FFFF)   dropped_q <= dropped_q + 32'd1;
        end
    end

    assign O_words_total   = total_q;
    assign O_words_dropped = dropped_q;
`else
    assign O_words_total   = '0;
    assign O_words_dropped = '0;
`endif

    assign O_next       = (state_q == NEXT);
    assign O_word_valid = (count_q != 5'd0);
    assign O_word       = O_word_valid ? mem[rd_ptr_q] : '0;
    assign O_fifo_count = count_q;
    assign O_bit_count  = bit_cnt_q;
    assign O_overflow   = overflow_q;
    assign O_dbg_state  = state_q;

endmodule

// File: tb/tb_noise_pack.sv
// Self-checking bench for noise_pack: directed scenarios plus a randomized run
// compared against a word-level queue model.
module tb_noise_pack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, en, clr, b, v, rdy;
  logic        O_next, O_word_valid, O_overflow;
  logic [31:0] O_word, O_words_total, O_words_dropped;
  logic [4:0]  O_fifo_count, O_bit_count;
  logic [1:0]  O_dbg_state;

  noise_pack #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .I_enable(en), .I_clear(clr), .I_bit(b), .I_bit_valid(v),
    .O_next(O_next), .O_word(O_word), .O_word_valid(O_word_valid), .I_word_ready(rdy),
    .O_fifo_count(O_fifo_count), .O_bit_count(O_bit_count), .O_overflow(O_overflow),
    .O_words_total(O_words_total), .O_words_dropped(O_words_dropped), .O_dbg_state(O_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int seen_pulses = 0;

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  bit          m_cap, m_gap, m_acc, m_ovf;
  int          m_bits;
  logic [31:0] m_word, m_total, m_drop;

  function automatic void model_reset();
    exp_q.delete();
    m_cap = 0; m_gap = 0; m_acc = 0; m_ovf = 0;
    m_bits = 0; m_word = '0; m_total = '0; m_drop = '0;
  endfunction

  function automatic void model_edge();
    int sz;
    bit pop, push, was_gap;
    logic [31:0] wd;
    m_acc = 0;
    if (clr) begin
      model_reset();
      return;
    end
    sz = exp_q.size();
    pop = (sz > 0) && rdy;
    push = 0;
    wd = '0;
    was_gap = m_gap;
    m_gap = 0;
    if (was_gap || !m_cap) begin
      m_cap = en;
    end else if (!en) begin
      m_cap = 0; m_bits = 0; m_word = '0;
    end else if (v) begin
      m_acc = 1;
      m_word = {m_word[30:0], b};
      m_bits++;
      if (m_bits == 32) begin
        push = 1; wd = m_word; m_bits = 0; m_word = '0; m_cap = 0; m_gap = 1;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (m_total != 32'hFFFF_FFFF) m_total++;
      if (sz < DEPTH || pop) exp_q.push_back(wd);
      else begin
        m_ovf = 1;
        if (m_drop != 32'hFFFF_FFFF) m_drop++;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic t_en, input logic t_clr, input logic t_b,
                      input logic t_v, input logic t_rdy);
    en = t_en; clr = t_clr; b = t_b; v = t_v; rdy = t_rdy;
    @(posedge clk);
    model_edge();
    #1;
    if (O_next === 1'b1) seen_pulses++;
  endtask

  task automatic feed_word(input logic [31:0] w, input bit sparse,
                           input logic r, input logic r_last);
    int idx = 0;
    int guard = 0;
    bit ph = 0;
    while (idx < 32 && guard < 300) begin
      guard++;
      ph = ~ph;
      tick(1'b1, 1'b0, w[31-idx], sparse ? ph : 1'b1, (idx == 31) ? r_last : r);
      if (m_acc) idx++;
    end
    if (idx < 32) begin
      n_checks++;
      $display("FAIL feed_word_timeout: accepted %0d bits, required 32", idx);
    end
  endtask

  task automatic do_clear();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (O_next !== 1'b0 || O_word_valid !== 1'b0 || O_fifo_count !== 5'd0)
      $display("FAIL reset_outputs: next=%b valid=%b count=%0d required 0/0/0", O_next, O_word_valid, O_fifo_count);
    else n_pass++;
    n_checks++; if (O_bit_count !== 5'd0 || O_overflow !== 1'b0 || O_word !== 32'd0)
      $display("FAIL reset_state: bits=%0d ovf=%b word=%h required 0/0/0", O_bit_count, O_overflow, O_word);
    else n_pass++;
    n_checks++; if (O_words_total !== 32'd0 || O_words_dropped !== 32'd0)
      $display("FAIL reset_stats: total=%0d dropped=%0d required 0/0", O_words_total, O_words_dropped);
    else n_pass++;
    rst = 1'b0;
    // reset in the middle of a word
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    n_checks++; if (O_bit_count !== 5'd10)
      $display("FAIL reset_pre_bits: got %0d required 10", O_bit_count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (O_bit_count !== 5'd0)
      $display("FAIL reset_async_bits: got %0d required 0", O_bit_count);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    // reset during the NEXT cycle
    feed_word($urandom(), 0, 1'b1, 1'b1);
    n_checks++; if (O_next !== 1'b1)
      $display("FAIL reset_pre_next: O_next=%b required 1", O_next);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (O_next !== 1'b0 || O_word_valid !== 1'b0)
      $display("FAIL reset_mid_next: next=%b valid=%b required 0/0", O_next, O_word_valid);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    seen_pulses = 0;
    repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (seen_pulses != 0 || O_word_valid !== 1'b0)
      $display("FAIL reset_abort: pulses=%0d valid=%b required 0/0", seen_pulses, O_word_valid);
    else n_pass++;
  endtask

  task automatic test_single_word();
    logic [31:0] w = 32'hDEADBEEF;
    do_clear();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) begin
      tick(1'b1, 1'b0, w[31-i], 1'b1, 1'b1);
      if (i < 31) begin
        n_checks++; if (O_bit_count !== 5'(i + 1) || O_next !== 1'b0)
          $display("FAIL single_progress: bits=%0d next=%b required %0d/0", O_bit_count, O_next, i + 1);
        else n_pass++;
      end
    end
    n_checks++; if (O_word !== 32'hDEADBEEF || O_word_valid !== 1'b1)
      $display("FAIL single_word: word=%h valid=%b required deadbeef/1", O_word, O_word_valid);
    else n_pass++;
    n_checks++; if (O_next !== 1'b1 || O_bit_count !== 5'd0)
      $display("FAIL single_next: next=%b bits=%0d required 1/0", O_next, O_bit_count);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (O_next !== 1'b0 || O_word_valid !== 1'b0 || O_fifo_count !== 5'd0)
      $display("FAIL single_after: next=%b valid=%b count=%0d required 0/0/0", O_next, O_word_valid, O_fifo_count);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int p0;
    do_clear();
    p0 = seen_pulses;
    for (int k = 1; k <= 5; k++) feed_word(32'(k), 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (O_fifo_count !== 5'd4 || O_overflow !== 1'b1)
      $display("FAIL ovf_state: count=%0d ovf=%b required 4/1", O_fifo_count, O_overflow);
    else n_pass++;
    n_checks++; if (seen_pulses - p0 != 5)
      $display("FAIL ovf_pulses: got %0d required 5", seen_pulses - p0);
    else n_pass++;
`ifdef NOISE_PACK_STATS_EN
    n_checks++; if (O_words_total !== 32'd5 || O_words_dropped !== 32'd1)
      $display("FAIL ovf_stats: total=%0d dropped=%0d required 5/1", O_words_total, O_words_dropped);
    else n_pass++;
`else
    n_checks++; if (O_words_total !== 32'd0 || O_words_dropped !== 32'd0)
      $display("FAIL ovf_stats_off: total=%0d dropped=%0d required 0/0", O_words_total, O_words_dropped);
    else n_pass++;
`endif
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (O_word_valid !== 1'b1 || O_word !== 32'(k))
        $display("FAIL ovf_drain: valid=%b word=%h required 1/%h", O_word_valid, O_word, 32'(k));
      else n_pass++;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_checks++; if (O_word_valid !== 1'b0 || O_overflow !== 1'b1)
      $display("FAIL ovf_empty: valid=%b ovf=%b required 0/1", O_word_valid, O_overflow);
    else n_pass++;
  endtask

  task automatic test_sparse_valid();
    logic [31:0] w = 32'hA5A5A5A5;
    int p0;
    do_clear();
    p0 = seen_pulses;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i[0] == 1'b0) tick(1'b1, 1'b0, w[31-(i/2)], 1'b1, 1'b0);
      else if (i == 63) tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      else tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n_checks++; if (O_bit_count !== ((i >= 62) ? 5'd0 : 5'(i / 2 + 1)))
        $display("FAIL sparse_bits: i=%0d got %0d", i, O_bit_count);
      else n_pass++;
    end
    n_checks++; if (O_word !== 32'hA5A5A5A5 || O_fifo_count !== 5'd1 || seen_pulses - p0 != 1)
      $display("FAIL sparse_word: word=%h count=%0d pulses=%0d required a5a5a5a5/1/1", O_word, O_fifo_count, seen_pulses - p0);
    else n_pass++;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (O_word !== 32'hA5A5A5A5 || O_word_valid !== 1'b1)
      $display("FAIL sparse_hold: word=%h valid=%b required a5a5a5a5/1", O_word, O_word_valid);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [31:0] r[4];
    do_clear();
    for (int k = 0; k < 4; k++) begin
      r[k] = $urandom();
      feed_word(r[k], 0, 1'b0, 1'b0);
    end
    feed_word(32'h12345678, 0, 1'b0, 1'b1);
    n_checks++; if (O_overflow !== 1'b0 || O_fifo_count !== 5'd4)
      $display("FAIL fullpop_state: ovf=%b count=%0d required 0/4", O_overflow, O_fifo_count);
    else n_pass++;
    r[0] = r[1]; r[1] = r[2]; r[2] = r[3]; r[3] = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (O_word !== r[k])
        $display("FAIL fullpop_order: k=%0d word=%h required %h", k, O_word, r[k]);
      else n_pass++;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_clear();
    do_clear();
    for (int k = 0; k < 5; k++) feed_word($urandom(), 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++; if (O_bit_count !== 5'd0 || O_word_valid !== 1'b0 || O_fifo_count !== 5'd0 ||
                    O_overflow !== 1'b0 || O_next !== 1'b0)
      $display("FAIL clear_state: bits=%0d valid=%b count=%0d ovf=%b next=%b required all 0",
               O_bit_count, O_word_valid, O_fifo_count, O_overflow, O_next);
    else n_pass++;
    feed_word(32'hCAFEF00D, 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (O_word !== 32'hCAFEF00D || O_fifo_count !== 5'd1)
      $display("FAIL clear_word: word=%h count=%0d required cafef00d/1", O_word, O_fifo_count);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    do_clear();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    n_checks++; if (O_bit_count !== 5'd20)
      $display("FAIL endrop_pre: bits=%0d required 20", O_bit_count);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (O_bit_count !== 5'd0)
      $display("FAIL endrop_cleared: bits=%0d required 0", O_bit_count);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    feed_word(32'h0F0F0F0F, 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (O_word !== 32'h0F0F0F0F || O_fifo_count !== 5'd1)
      $display("FAIL endrop_word: word=%h count=%0d required 0f0f0f0f/1", O_word, O_fifo_count);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] e_word, e_tot, e_drp;
    do_clear();
    for (int c = 0; c < 1500; c++) begin
      tick(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0));
      e_word = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
`ifdef NOISE_PACK_STATS_EN
      e_tot = m_total; e_drp = m_drop;
`else
      e_tot = 32'd0; e_drp = 32'd0;
`endif
      n_checks++; if (O_next !== m_gap || O_bit_count !== 5'(m_bits) || O_overflow !== m_ovf)
        $display("FAIL rand_ctrl: c=%0d next=%b bits=%0d ovf=%b required %b/%0d/%b",
                 c, O_next, O_bit_count, O_overflow, m_gap, m_bits, m_ovf);
      else n_pass++;
      n_checks++; if (O_word !== e_word || O_fifo_count !== 5'(exp_q.size()) ||
                      O_word_valid !== (exp_q.size() > 0))
        $display("FAIL rand_fifo: c=%0d word=%h count=%0d valid=%b required %h/%0d",
                 c, O_word, O_fifo_count, O_word_valid, e_word, exp_q.size());
      else n_pass++;
      n_checks++; if (O_words_total !== e_tot || O_words_dropped !== e_drp)
        $display("FAIL rand_stats: c=%0d total=%0d dropped=%0d required %0d/%0d",
                 c, O_words_total, O_words_dropped, e_tot, e_drp);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; b = 1'b0; v = 1'b0; rdy = 1'b0;
    model_reset();
    test_reset();
    test_single_word();
    test_overflow();
    test_sparse_valid();
    test_full_pop();
    test_clear();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
